// File: rtl/pe_tile_scheduler_if.sv
// rtl/pe_tile_scheduler_if.sv - data tile / weight request handshake bundle of the PE tile scheduler
interface pe_tile_scheduler_if #(
  parameter int IDX_W = 9,
  parameter int OD_W  = 8
);
  logic             data_valid_o;
  logic             data_ready_i;
  logic [IDX_W-1:0] data_x_index_o;
  logic [IDX_W-1:0] data_y_index_o;
  logic             weight_valid_o;
  logic             weight_ready_i;
  logic             weight_size_type_o;
  logic [OD_W-1:0]  weight_od_o;

  modport master (
    output data_valid_o, data_x_index_o, data_y_index_o,
    output weight_valid_o, weight_size_type_o, weight_od_o,
    input  data_ready_i, weight_ready_i
  );

  modport slave (
    input  data_valid_o, data_x_index_o, data_y_index_o,
    input  weight_valid_o, weight_size_type_o, weight_od_o,
    output data_ready_i, weight_ready_i
  );
endinterface

// File: rtl/pe_tile_scheduler.sv
// rtl/pe_tile_scheduler.sv - walks od/tx/ty tiles, issuing joint data+weight requests
// Optional stall counter output stall_cnt_o is built when SCHED_PERF_CNT_EN is defined.
module pe_tile_scheduler #(
  parameter int IDX_W        = 9,
  parameter int OD_W         = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [IDX_W-1:0] cfg_tiles_x_i,
  input  logic [IDX_W-1:0] cfg_tiles_y_i,
  input  logic [OD_W-1:0]  cfg_od_i,
  input  logic             cfg_size_type_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef SCHED_PERF_CNT_EN
  output logic [15:0]      stall_cnt_o,
`endif
  pe_tile_scheduler_if.master dif
);

  localparam int DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [OD_W-1:0]  od_q, od_d;
  logic [IDX_W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [IDX_W-1:0] x_q, x_d, y_q, y_d;
  logic [IDX_W-1:0] cfg_tx_q, cfg_tx_d, cfg_ty_q, cfg_ty_d;
  logic [OD_W-1:0]  cfg_od_q, cfg_od_d;
  logic             size_q, size_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             wst_q, wst_d;
  logic             xfer, last, start_acc;
  logic [IDX_W-1:0] step;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0]      stall_q, stall_d;
`endif

  always_comb begin
    state_d   = state_q;
    od_d      = od_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    x_d       = x_q;
    y_d       = y_q;
    cfg_tx_d  = cfg_tx_q;
    cfg_ty_d  = cfg_ty_q;
    cfg_od_d  = cfg_od_q;
    size_d    = size_q;
    drain_d   = drain_q;
    start_acc = 1'b0;
    step      = size_q ? IDX_W'(4) : IDX_W'(6);
    xfer      = valid_q && dif.data_ready_i && dif.weight_ready_i;
    last      = (od_q == cfg_od_q - OD_W'(1)) && (tx_q == cfg_tx_q - IDX_W'(1))
             && (ty_q == cfg_ty_q - IDX_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          start_acc = 1'b1;
          cfg_tx_d  = cfg_tiles_x_i;
          cfg_ty_d  = cfg_tiles_y_i;
          cfg_od_d  = cfg_od_i;
          size_d    = cfg_size_type_i;
          if (cfg_tiles_x_i == '0 || cfg_tiles_y_i == '0 || cfg_od_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (last) begin
            state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
            drain_d = DW'(DRAIN_LOAD);
          end else if (od_q == cfg_od_q - OD_W'(1)) begin
            od_d = '0;
            if (tx_q == cfg_tx_q - IDX_W'(1)) begin
              tx_d = '0;
              x_d  = '0;
              ty_d = ty_q + IDX_W'(1);
              y_d  = y_q + step;
            end else begin
              tx_d = tx_q + IDX_W'(1);
              x_d  = x_q + step;
            end
          end else begin
            od_d = od_q + OD_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
    end

    // Counters and index accumulators only hold live values while streaming,
    // so the index outputs read zero everywhere else.
    if (state_d != S_STREAM) begin
      od_d = '0;
      tx_d = '0;
      ty_d = '0;
      x_d  = '0;
      y_d  = '0;
    end

    valid_d = (state_d == S_STREAM);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    wst_d   = valid_d ? size_d : 1'b0;

`ifdef SCHED_PERF_CNT_EN
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (valid_q && !(dif.data_ready_i && dif.weight_ready_i) && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      od_q     <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cfg_tx_q <= '0;
      cfg_ty_q <= '0;
      cfg_od_q <= '0;
      size_q   <= 1'b0;
      drain_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      wst_q    <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      od_q     <= od_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cfg_tx_q <= cfg_tx_d;
      cfg_ty_q <= cfg_ty_d;
      cfg_od_q <= cfg_od_d;
      size_q   <= size_d;
      drain_q  <= drain_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wst_q    <= wst_d;
`ifdef SCHED_PERF_CNT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign dif.data_valid_o       = valid_q;
  assign dif.weight_valid_o     = valid_q;
  assign dif.data_x_index_o     = x_q;
  assign dif.data_y_index_o     = y_q;
  assign dif.weight_od_o        = od_q;
  assign dif.weight_size_type_o = wst_q;
`ifdef SCHED_PERF_CNT_EN
  assign stall_cnt_o            = stall_q;
`endif

endmodule
